// File: rtl/mini_src_control_unit.sv
// Hardwired Mini SRC control unit: sequences T0-T6 fetch/execute and decodes datapath strobes.
// Outputs are a combinational Moore decode of the step and ir_in; stop is honoured only at instruction boundaries.
module mini_src_control_unit #(
   parameter logic [4:0] INC_OP = 5'b11111,
   parameter int         CNT_W  = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [31:0]      ir_in,
   input  logic             stop,
   output logic [15:0]      reg_en,
   output logic [15:0]      reg_out,
   output logic             Pout,
   output logic             Pen,
   output logic             MARen,
   output logic             MDRen,
   output logic             MDROut,
   output logic             Read,
   output logic             IRen,
   output logic             Yen,
   output logic             ZLOen,
   output logic             ZHIen,
   output logic             ZLOout,
   output logic             ZHIout,
   output logic             HIen,
   output logic             LOen,
   output logic [4:0]       alu_control,
   output logic             run,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   state_t             state_q, state_d;
   logic               illegal_q, illegal_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic       is_alu3, is_muldiv, is_unary, is_nop, is_halt;
   logic       retire;

   assign op = ir_in[31:27];
   assign ra = ir_in[26:23];
   assign rb = ir_in[22:19];
   assign rc = ir_in[18:15];

   assign is_alu3   = (op >= 5'd3) && (op <= 5'd11);
   assign is_muldiv = (op == 5'd14) || (op == 5'd15);
   assign is_unary  = (op == 5'd16) || (op == 5'd17);
   assign is_nop    = (op == 5'd26);
   assign is_halt   = (op == 5'd27);

   always_comb begin
      state_d     = state_q;
      illegal_d   = illegal_q;
      cnt_d       = cnt_q;
      retire      = 1'b0;
      reg_en      = '0;
      reg_out     = '0;
      Pout        = 1'b0;
      Pen         = 1'b0;
      MARen       = 1'b0;
      MDRen       = 1'b0;
      MDROut      = 1'b0;
      Read        = 1'b0;
      IRen        = 1'b0;
      Yen         = 1'b0;
      ZLOen       = 1'b0;
      ZHIen       = 1'b0;
      ZLOout      = 1'b0;
      ZHIout      = 1'b0;
      HIen        = 1'b0;
      LOen        = 1'b0;
      alu_control = '0;

      case (state_q)
         S_RESET: state_d = S_T0;
         S_T0: begin
            Pout        = 1'b1;
            MARen       = 1'b1;
            ZLOen       = 1'b1;
            alu_control = INC_OP;
            state_d     = S_T1;
         end
         S_T1: begin
            ZLOout  = 1'b1;
            Pen     = 1'b1;
            Read    = 1'b1;
            MDRen   = 1'b1;
            state_d = S_T2;
         end
         S_T2: begin
            MDROut  = 1'b1;
            IRen    = 1'b1;
            state_d = S_T3;
         end
         S_T3: begin
            if (is_alu3 || is_muldiv) begin
               reg_out = 16'(1) << rb;
               Yen     = 1'b1;
               state_d = S_T4;
            end else if (is_unary) begin
               reg_out     = 16'(1) << rb;
               alu_control = op;
               ZLOen       = 1'b1;
               state_d     = S_T4;
            end else if (is_nop) begin
               retire = 1'b1;
            end else if (is_halt) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_HALT;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_T4: begin
            if (is_alu3 || is_muldiv) begin
               reg_out     = 16'(1) << rc;
               alu_control = op;
               ZLOen       = 1'b1;
               ZHIen       = is_muldiv;
               state_d     = S_T5;
            end else begin
               ZLOout = is_unary;
               reg_en = is_unary ? (16'(1) << ra) : 16'h0000;
               retire = 1'b1;
            end
         end
         S_T5: begin
            ZLOout = 1'b1;
            if (is_muldiv) begin
               LOen    = 1'b1;
               state_d = S_T6;
            end else begin
               reg_en = 16'(1) << ra;
               retire = 1'b1;
            end
         end
         S_T6: begin
            ZHIout = 1'b1;
            HIen   = 1'b1;
            retire = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase

      // Every retirement lands on an instruction boundary, the only place stop is honoured.
      if (retire) begin
         cnt_d   = cnt_q + CNT_W'(1);
         state_d = stop ? S_HALT : S_T0;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= S_RESET;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   assign run         = (state_q != S_RESET) && (state_q != S_HALT);
   assign illegal     = illegal_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Bench for mini_src_control_unit: directed and random instructions checked step by step against a class-level model.
module tb_mini_src_control_unit;

   typedef struct packed {
      logic [15:0] reg_en;
      logic [15:0] reg_out;
      logic pout, pen, maren, mdren, mdrout, read, iren, yen;
      logic zloen, zhien, zloout, zhiout, hien, loen;
      logic [4:0] alu;
      logic run;
   } outs_t;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] ir_in = '0;
   logic        stop = 1'b0;
   logic [15:0] reg_en, reg_out;
   logic        Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen;
   logic        ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen;
   logic [4:0]  alu_control;
   logic        run, illegal;
   logic [15:0] instr_count;
   outs_t       obs;

   int n_cmp  = 0;
   int n_fail = 0;

   outs_t       exp_q[$];
   bit          m_retire, m_halt, m_illegal;
   logic [15:0] count_m = '0;

   mini_src_control_unit #(.INC_OP(5'b11111), .CNT_W(16)) dut (
      .clk(clk), .clr(clr), .ir_in(ir_in), .stop(stop),
      .reg_en(reg_en), .reg_out(reg_out),
      .Pout(Pout), .Pen(Pen), .MARen(MARen), .MDRen(MDRen), .MDROut(MDROut),
      .Read(Read), .IRen(IRen), .Yen(Yen),
      .ZLOen(ZLOen), .ZHIen(ZHIen), .ZLOout(ZLOout), .ZHIout(ZHIout),
      .HIen(HIen), .LOen(LOen), .alu_control(alu_control),
      .run(run), .illegal(illegal), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   assign obs = {reg_en, reg_out, Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen,
                 ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen, alu_control, run};

   function automatic outs_t t0_vec();
      outs_t v = '0;
      v.run = 1'b1; v.pout = 1'b1; v.maren = 1'b1; v.zloen = 1'b1; v.alu = 5'b11111;
      return v;
   endfunction

   // Expected strobes for T1 onward of one instruction, built from its class.
   function automatic void model_instr(input logic [31:0] ir);
      logic [4:0] op = ir[31:27];
      logic [3:0] ra = ir[26:23];
      logic [3:0] rb = ir[22:19];
      logic [3:0] rc = ir[18:15];
      bit         md = (op == 5'd14) || (op == 5'd15);
      outs_t v;
      exp_q.delete();
      m_retire = 1; m_halt = 0; m_illegal = 0;
      v = '0; v.run = 1; v.zloout = 1; v.pen = 1; v.read = 1; v.mdren = 1; exp_q.push_back(v);
      v = '0; v.run = 1; v.mdrout = 1; v.iren = 1; exp_q.push_back(v);
      if ((op >= 5'd3 && op <= 5'd11) || md) begin
         v = '0; v.run = 1; v.reg_out = 16'(1) << rb; v.yen = 1; exp_q.push_back(v);
         v = '0; v.run = 1; v.reg_out = 16'(1) << rc; v.alu = op; v.zloen = 1; v.zhien = md;
         exp_q.push_back(v);
         v = '0; v.run = 1; v.zloout = 1;
         if (md) v.loen = 1; else v.reg_en = 16'(1) << ra;
         exp_q.push_back(v);
         if (md) begin
            v = '0; v.run = 1; v.zhiout = 1; v.hien = 1; exp_q.push_back(v);
         end
      end else if (op == 5'd16 || op == 5'd17) begin
         v = '0; v.run = 1; v.reg_out = 16'(1) << rb; v.alu = op; v.zloen = 1; exp_q.push_back(v);
         v = '0; v.run = 1; v.zloout = 1; v.reg_en = 16'(1) << ra; exp_q.push_back(v);
      end else begin
         v = '0; v.run = 1; exp_q.push_back(v);
         if (op == 5'd27) m_halt = 1;
         else if (op != 5'd26) begin m_halt = 1; m_illegal = 1; m_retire = 0; end
      end
   endfunction

   task automatic do_reset();
      clr = 1'b0; stop = 1'b0;
      #1;
      @(negedge clk);
      clr = 1'b1; count_m = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      clr = 1'b0;
      #3;
      n_cmp++;
      if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs); end
      n_cmp++;
      if (instr_count !== 16'd0 || illegal !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: count %0d illegal %b expected 0 0", instr_count, illegal);
      end
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== t0_vec()) begin n_fail++; $display("FAIL reset_to_t0: got %h expected %h", obs, t0_vec()); end
   endtask

   task automatic test_directed();
      logic [31:0] irs[4] = '{32'h28918000, {5'd14, 4'd9, 4'd4, 4'd5, 15'd0},
                              {5'd17, 4'd7, 4'd6, 4'd0, 15'd0}, {5'd26, 27'd0}};
      for (int k = 0; k < 4; k++) begin
         model_instr(irs[k]);
         ir_in = irs[k];
         for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== exp_q[i]) begin
               n_fail++; $display("FAIL directed%0d_T%0d: got %h expected %h", k, i + 1, obs, exp_q[i]);
            end
         end
         @(posedge clk); #1;
         count_m++;
         n_cmp++;
         if (obs !== t0_vec()) begin n_fail++; $display("FAIL directed%0d_next: got %h expected %h", k, obs, t0_vec()); end
         n_cmp++;
         if (instr_count !== count_m) begin
            n_fail++; $display("FAIL directed%0d_count: got %0d expected %0d", k, instr_count, count_m);
         end
      end
   endtask

   task automatic test_clr_mid();
      model_instr(32'h28918000);
      ir_in = 32'h28918000;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (obs !== exp_q[i]) begin n_fail++; $display("FAIL clrmid_T%0d: got %h expected %h", i + 1, obs, exp_q[i]); end
      end
      #2 clr = 1'b0;
      #1;
      n_cmp++;
      if (obs !== '0 || instr_count !== 16'd0) begin
         n_fail++; $display("FAIL clrmid_async: got %h count %0d expected 0 0", obs, instr_count);
      end
      @(negedge clk);
      clr = 1'b1; count_m = '0;
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== t0_vec() || instr_count !== 16'd0) begin
         n_fail++; $display("FAIL clrmid_release: got %h count %0d expected %h 0", obs, instr_count, t0_vec());
      end
   endtask

   task automatic test_halting();
      logic [31:0] irs[4] = '{32'h28918000, {5'd27, 27'd0}, {5'd31, 27'd0}, {5'd20, 27'h1234567}};
      bit          stp[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 4; k++) begin
         do_reset();
         model_instr(irs[k]);
         ir_in = irs[k];
         for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== exp_q[i]) begin
               n_fail++; $display("FAIL halting%0d_T%0d: got %h expected %h", k, i + 1, obs, exp_q[i]);
            end
            if (i == 2) stop = stp[k];
         end
         @(posedge clk); #1;
         if (m_retire) count_m++;
         n_cmp++;
         if (obs !== '0 || instr_count !== count_m || illegal !== m_illegal) begin
            n_fail++;
            $display("FAIL halting%0d_halt: got %h count %0d illegal %b expected 0 %0d %b",
                     k, obs, instr_count, illegal, count_m, m_illegal);
         end
         stop = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         n_cmp++;
         if (obs !== '0 || illegal !== m_illegal) begin
            n_fail++; $display("FAIL halting%0d_stays: got %h illegal %b expected 0 %b", k, obs, illegal, m_illegal);
         end
      end
   endtask

   task automatic test_random();
      logic [4:0]  ops[14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                               5'd14, 5'd15, 5'd16, 5'd17, 5'd26};
      logic [31:0] ir;
      do_reset();
      for (int k = 0; k < 40; k++) begin
         ir = {ops[$urandom_range(0, 13)], 27'($urandom)};
         model_instr(ir);
         ir_in = ir;
         for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== exp_q[i]) begin
               n_fail++; $display("FAIL random%0d_T%0d ir %h: got %h expected %h", k, i + 1, ir, obs, exp_q[i]);
            end
         end
         @(posedge clk); #1;
         count_m++;
         n_cmp++;
         if (obs !== t0_vec() || instr_count !== count_m) begin
            n_fail++; $display("FAIL random%0d_retire: got %h count %0d expected %h %0d",
                               k, obs, instr_count, t0_vec(), count_m);
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_clr_mid();
      test_halting();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mini_src_control_unit.md
Name: mini_src_control_unit

Overview:
Hardwired control unit for the Mini SRC CPU, sitting directly upstream of the datapath. It generates, cycle by cycle, every enable, output-select, memory and ALU-op strobe the datapath consumes. It sequences the T0–T6 fetch/execute steps for three-register ALU, mul/div, unary, nop and halt instructions.

Parameters:
INC_OP, 5'b11111, alu_control code for PC increment during T0.
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  in  1  system clock; all state changes on rising edge.
clr  in  1  asynchronous active-low reset.
ir_in  in  32  IR register contents from the datapath.
stop  in  1  level; halt at next instruction boundary.
reg_en  out  16  one-hot R0–R15 load enables.
reg_out  out  16  one-hot R0–R15 bus drive selects.
Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen  out  1 each  datapath strobes.
ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen  out  1 each  Z/HI/LO strobes.
alu_control  out  5  ALU operation.
run  out  1  high while sequencing; low in RESET/HALT.
illegal  out  1  sticky; set on undefined opcode.
instr_count  out  CNT_W  retired instructions.

Behaviour:
- Decode fields: op=ir_in[31:27], Ra=ir_in[26:23], Rb=ir_in[22:19], Rc=ir_in[18:15].
- Classes:
  - ALU3 = op 3..11.
  - MULDIV = op 14,15.
  - UNARY = op 16,17.
  - NOP = 26.
  - HALT = 27.
  - Any other op is illegal.
- States: RESET, T0–T6, HALT.
- Outputs are a Moore function of state and ir_in, decoded combinationally. The datapath samples them at the rising edge ending the state.
- Every strobe not listed for a state is 0. alu_control is 0 unless listed.
- clr low: state=RESET immediately, regardless of the current step; illegal=0, instr_count=0; all outputs 0, run=0.
- First edge after clr release: RESET -> T0.
- Fetch sequence:
  - T0: Pout, MARen, ZLOen, alu_control=INC_OP.
  - T1: ZLOout, Pen, Read, MDRen.
  - T2: MDROut, IRen.
- T3 (decode ir_in, valid since the T2 edge):
  - ALU3/MULDIV: reg_out[Rb], Yen.
  - UNARY: reg_out[Rb], alu_control=op, ZLOen.
  - NOP -> T0.
  - HALT -> HALT.
  - Illegal: set illegal, -> HALT.
- T4:
  - ALU3: reg_out[Rc], alu_control=op, ZLOen.
  - MULDIV: reg_out[Rc], alu_control=op, ZLOen, ZHIen.
  - UNARY: ZLOout, reg_en[Ra], -> T0.
- T5:
  - ALU3: ZLOout, reg_en[Ra], -> T0.
  - MULDIV: ZLOout, LOen.
- T6 (MULDIV only): ZHIout, HIen, -> T0.
- Retirement:
  - instr_count increments on each transition into T0 from T3, T4, T5 or T6, and on T3 -> HALT for the halt opcode.
  - Illegal opcodes do not increment instr_count.
  - instr_count wraps modulo 2^CNT_W.
- stop:
  - Sampled only on transitions that would enter T0. If high, go to HALT instead; the retiring instruction is still counted.
  - stop mid-instruction never truncates the sequence.
- HALT is left only by reset.
- reg_out and reg_en are always one-hot or zero. Ra=Rb or Ra=Rc is legal.
- No multi-driver condition: at most one *out strobe (reg_out bit, MDROut, Pout, ZLOout, ZHIout) is high in any state.

Test Plan:
1. Reset release, ir_in=32'h28918000 (op 5 ALU3, Ra=R1, Rb=R2, Rc=R3) → states T0..T5 in order.
   - T3: reg_out=16'h0004 with Yen.
   - T4: reg_out=16'h0008, alu_control=5'b00101.
   - T5: reg_en=16'h0002 with ZLOout.
   - Then T0 again, instr_count=1.
2. Pull clr low during T4 → all outputs 0 asynchronously, before the next clk edge; release → T0 on the following edge, instr_count=0.
3. MULDIV op 14 with Rb=R4, Rc=R5 → ZLOen&ZHIen in T4, LOen in T5, HIen in T6, back to T0; six fetch/execute steps after T0.
4. UNARY op 17, Ra=R7, Rb=R6 → done in T4 with reg_en=16'h0080; next state T0.
5. Assert stop during T3 of an ALU3 instruction → instruction completes through T5, state HALT, run=0, instr_count incremented once.
6. ir_in op=5'd31 → illegal=1 in HALT, instr_count unchanged, and stays there until clr low.
